// File: rtl/mem_access_if.sv
// Request/response and DataMemory bus for mem_access_unit.
// The slave side belongs to the unit; the master side is the pipeline/memory environment.
interface mem_access_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_load;
    logic                  req_store;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  stall;
    logic [31:0]           rdata;
    logic                  rdata_valid;
    logic                  done;
    logic                  err;
    logic                  mem_load;
    logic                  mem_store;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  req_valid, req_load, req_store, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_rdata,
        output stall, rdata, rdata_valid, done, err,
        output mem_load, mem_store, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_load, req_store, req_size, req_unsigned, req_addr, req_wdata,
        output mem_rdata,
        input  stall, rdata, rdata_valid, done, err,
        input  mem_load, mem_store, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MIPS load/store front end for a word-wide DataMemory: lane extraction/extension,
// big-endian sub-word stores as a stalled 2-cycle read-modify-write, and error flagging.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic         clk,
    input  logic         reset,
    mem_access_if.slave  bus
);
    localparam int AW = ADDR_WIDTH;

    typedef enum logic {IDLE, WRITE} state_t;
    state_t state, state_nxt;

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            2'b00:   r = uns ? {24'd0, b} : 32'(b);
            2'b01:   r = uns ? {16'd0, h} : 32'(h);
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic [31:0] wd);
        logic [31:0] r;
        r = word;
        if (size == 2'b01) begin
            if (off[1]) r[15:0]  = wd[15:0];
            else        r[31:16] = wd[15:0];
        end else begin
            case (off)
                2'd0:    r[31:24] = wd[7:0];
                2'd1:    r[23:16] = wd[7:0];
                2'd2:    r[15:8]  = wd[7:0];
                default: r[7:0]   = wd[7:0];
            endcase
        end
        return r;
    endfunction

    logic          accept, bad;
    logic          mem_load, mem_store, stall;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;

    // stage p0: decode request, drive memory, extract/merge
    logic          vld_p0, done_p0, err_p0;
    logic [31:0]   rdata_p0, merge_p0;

    assign accept = bus.req_valid & (bus.req_load | bus.req_store);
    assign bad    = (bus.req_load & bus.req_store)
                  | (bus.req_size == 2'b11)
                  | ((bus.req_size == 2'b01) & bus.req_addr[0])
                  | ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00))
                  | (bus.req_addr[31:AW+2] != '0);

    assign rdata_p0 = extend_load(bus.mem_rdata, bus.req_size, bus.req_addr[1:0], bus.req_unsigned);
    assign merge_p0 = merge_store(bus.mem_rdata, bus.req_size, bus.req_addr[1:0], bus.req_wdata);

    // stage p1: registered results and RMW latches
    logic          vld_p1, done_p1, err_p1;
    logic [31:0]   rdata_p1, wdata_p1;
    logic [AW-1:0] addr_p1;

    always_comb begin
        state_nxt = state;
        mem_load  = 1'b0;
        mem_store = 1'b0;
        mem_addr  = bus.req_addr[AW+1:2];
        mem_wdata = '0;
        stall     = 1'b0;
        vld_p0    = 1'b0;
        done_p0   = 1'b0;
        err_p0    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bad) begin
                        err_p0  = 1'b1;
                        done_p0 = 1'b1;
                    end else if (bus.req_load) begin
                        mem_load = 1'b1;
                        vld_p0   = 1'b1;
                        done_p0  = 1'b1;
                    end else if (bus.req_size == 2'b10) begin
                        mem_store = 1'b1;
                        mem_wdata = bus.req_wdata;
                        done_p0   = 1'b1;
                    end else begin
                        mem_load  = 1'b1;
                        stall     = 1'b1;
                        state_nxt = WRITE;
                    end
                end
            end
            WRITE: begin
                mem_store = 1'b1;
                mem_addr  = addr_p1;
                mem_wdata = wdata_p1;
                done_p0   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Reset must never let a half-finished RMW touch memory.
        if (reset) begin
            mem_load  = 1'b0;
            mem_store = 1'b0;
            mem_wdata = '0;
            stall     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            vld_p1   <= 1'b0;
            done_p1  <= 1'b0;
            err_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            state   <= state_nxt;
            vld_p1  <= vld_p0;
            done_p1 <= done_p0;
            err_p1  <= err_p0;
            if (vld_p0) rdata_p1 <= rdata_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (stall) begin
            wdata_p1 <= merge_p0;
            addr_p1  <= mem_addr;
        end
    end

    assign bus.mem_load    = mem_load;
    assign bus.mem_store   = mem_store;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;
    assign bus.stall       = stall;
    assign bus.rdata       = rdata_p1;
    assign bus.rdata_valid = vld_p1;
    assign bus.done        = done_p1;
    assign bus.err         = err_p1;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 1024-word DataMemory.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;

    mem_access_if #(.ADDR_WIDTH(10)) bus ();

    mem_access_unit #(.ADDR_WIDTH(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] dmem [1024];
    assign bus.mem_rdata = dmem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_store) dmem[bus.mem_addr] <= bus.mem_wdata;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_req(input logic ld, input logic st, input logic [1:0] sz, input logic un,
                           input logic [31:0] addr, input logic [31:0] wd);
        bus.req_valid    = 1'b1;
        bus.req_load     = ld;
        bus.req_store    = st;
        bus.req_size     = sz;
        bus.req_unsigned = un;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
    endtask

    task automatic put_idle();
        bus.req_valid = 1'b0;
        bus.req_load  = 1'b0;
        bus.req_store = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [1:0] sz, input logic un,
                           input logic [31:0] addr, input logic [31:0] exp);
        put_req(1'b1, 1'b0, sz, un, addr, 32'd0);
        #4;
        check_vec({tag, "_mem_load"}, 32'(bus.mem_load), 32'd1);
        check_vec({tag, "_stall"}, 32'(bus.stall), 32'd0);
        tick();
        check_vec({tag, "_rdata"}, bus.rdata, exp);
        check_vec({tag, "_rvalid"}, 32'(bus.rdata_valid), 32'd1);
        check_vec({tag, "_done"}, 32'(bus.done), 32'd1);
        put_idle();
    endtask

    task automatic do_sw(input string tag, input logic [31:0] addr, input logic [31:0] wd);
        put_req(1'b0, 1'b1, 2'b10, 1'b0, addr, wd);
        #4;
        check_vec({tag, "_mem_store"}, 32'(bus.mem_store), 32'd1);
        check_vec({tag, "_wdata"}, bus.mem_wdata, wd);
        check_vec({tag, "_stall"}, 32'(bus.stall), 32'd0);
        tick();
        check_vec({tag, "_done"}, 32'(bus.done), 32'd1);
        check_vec({tag, "_rvalid"}, 32'(bus.rdata_valid), 32'd0);
        put_idle();
    endtask

    task automatic do_subst(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] merged);
        put_req(1'b0, 1'b1, sz, 1'b0, addr, wd);
        #4;
        check_vec({tag, "_acc_stall"}, 32'(bus.stall), 32'd1);
        check_vec({tag, "_acc_load"}, 32'(bus.mem_load), 32'd1);
        check_vec({tag, "_acc_store"}, 32'(bus.mem_store), 32'd0);
        tick();
        #4;
        check_vec({tag, "_wr_stall"}, 32'(bus.stall), 32'd0);
        check_vec({tag, "_wr_store"}, 32'(bus.mem_store), 32'd1);
        check_vec({tag, "_wr_wdata"}, bus.mem_wdata, merged);
        check_vec({tag, "_wr_addr"}, 32'(bus.mem_addr), 32'(addr[11:2]));
        tick();
        check_vec({tag, "_done"}, 32'(bus.done), 32'd1);
        put_idle();
    endtask

    task automatic do_bad(input string tag, input logic ld, input logic st, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] exp_rdata);
        put_req(ld, st, sz, 1'b0, addr, 32'hDEADBEEF);
        #4;
        check_vec({tag, "_no_load"}, 32'(bus.mem_load), 32'd0);
        check_vec({tag, "_no_store"}, 32'(bus.mem_store), 32'd0);
        check_vec({tag, "_stall"}, 32'(bus.stall), 32'd0);
        tick();
        check_vec({tag, "_err"}, 32'(bus.err), 32'd1);
        check_vec({tag, "_done"}, 32'(bus.done), 32'd1);
        check_vec({tag, "_rvalid"}, 32'(bus.rdata_valid), 32'd0);
        check_vec({tag, "_rdata"}, bus.rdata, exp_rdata);
        put_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] t6_addr [4];
        logic [31:0] t6_data [4];
        for (int i = 0; i < 1024; i++) dmem[i] = 32'd0;
        reset = 1'b1;
        put_idle();
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        tick();
        // Request presented during reset must not reach memory
        put_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        #4;
        check_vec("rst_mem_load", 32'(bus.mem_load), 32'd0);
        tick();
        check_vec("rst_rdata", bus.rdata, 32'd0);
        check_vec("rst_rvalid", 32'(bus.rdata_valid), 32'd0);
        check_vec("rst_done", 32'(bus.done), 32'd0);
        check_vec("rst_err", 32'(bus.err), 32'd0);
        put_idle();
        reset = 1'b0;
        tick();

        // T1
        do_sw("t1_sw", 32'h010, 32'h12345678);
        check_vec("t1_mem", dmem[4], 32'h12345678);
        do_load("t1_lw", 2'b10, 1'b0, 32'h010, 32'h12345678);

        // no-op request: no access and no pulses
        put_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h010, 32'd0);
        #4;
        check_vec("noop_load", 32'(bus.mem_load), 32'd0);
        tick();
        check_vec("noop_done", 32'(bus.done), 32'd0);
        check_vec("noop_rvalid", 32'(bus.rdata_valid), 32'd0);
        put_idle();

        // T2
        do_subst("t2_sb", 2'b00, 32'h011, 32'h000000AB, 32'h12AB5678);
        check_vec("t2_mem", dmem[4], 32'h12AB5678);
        do_load("t2_lb", 2'b00, 1'b0, 32'h011, 32'hFFFFFFAB);
        do_load("t2_lbu", 2'b00, 1'b1, 32'h011, 32'h000000AB);

        // T3
        do_subst("t3_sh", 2'b01, 32'h012, 32'h00008001, 32'h12AB8001);
        do_load("t3_lh", 2'b01, 1'b0, 32'h012, 32'hFFFF8001);
        do_load("t3_lhu", 2'b01, 1'b1, 32'h012, 32'h00008001);
        do_load("t3_lh0", 2'b01, 1'b0, 32'h010, 32'h000012AB);
        do_load("t3_lb3", 2'b00, 1'b0, 32'h013, 32'h00000001);

        // T4
        do_bad("t4_lw_mis", 1'b1, 1'b0, 2'b10, 32'h013, 32'h00000001);
        do_bad("t4_sh_mis", 1'b0, 1'b1, 2'b01, 32'h011, 32'h00000001);
        do_bad("t4_range", 1'b1, 1'b0, 2'b10, 32'h1000, 32'h00000001);
        do_bad("t4_size11", 1'b1, 1'b0, 2'b11, 32'h010, 32'h00000001);
        do_bad("t4_ldst", 1'b1, 1'b1, 2'b10, 32'h010, 32'h00000001);
        tick();
        check_vec("t4_err_pulse", 32'(bus.err), 32'd0);
        check_vec("t4_mem_kept", dmem[4], 32'h12AB8001);

        // T5
        do_sw("t5_sw", 32'h020, 32'hCAFEBABE);
        put_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h020, 32'h00000011);
        #4;
        check_vec("t5_acc_stall", 32'(bus.stall), 32'd1);
        tick();
        reset = 1'b1;
        #4;
        check_vec("t5_rst_store", 32'(bus.mem_store), 32'd0);
        check_vec("t5_rst_wdata", bus.mem_wdata, 32'd0);
        tick();
        reset = 1'b0;
        put_idle();
        check_vec("t5_mem", dmem[8], 32'hCAFEBABE);
        check_vec("t5_rdata", bus.rdata, 32'd0);
        check_vec("t5_rvalid", 32'(bus.rdata_valid), 32'd0);
        check_vec("t5_done", 32'(bus.done), 32'd0);
        check_vec("t5_err", 32'(bus.err), 32'd0);
        #4;
        check_vec("t5_idle_store", 32'(bus.mem_store), 32'd0);
        tick();
        do_load("t5_lw", 2'b10, 1'b0, 32'h020, 32'hCAFEBABE);

        // T6
        do_sw("t6_sw0", 32'h024, 32'h0BADF00D);
        do_sw("t6_sw1", 32'h028, 32'h55AA33CC);
        t6_addr[0] = 32'h010; t6_data[0] = 32'h12AB8001;
        t6_addr[1] = 32'h020; t6_data[1] = 32'hCAFEBABE;
        t6_addr[2] = 32'h024; t6_data[2] = 32'h0BADF00D;
        t6_addr[3] = 32'h028; t6_data[3] = 32'h55AA33CC;
        for (int i = 0; i < 4; i++) begin
            put_req(1'b1, 1'b0, 2'b10, 1'b0, t6_addr[i], 32'd0);
            #4;
            check_vec($sformatf("t6_stall%0d", i), 32'(bus.stall), 32'd0);
            tick();
            check_vec($sformatf("t6_rvalid%0d", i), 32'(bus.rdata_valid), 32'd1);
            check_vec($sformatf("t6_rdata%0d", i), bus.rdata, t6_data[i]);
        end
        put_idle();
        tick();
        check_vec("t6_rvalid_end", 32'(bus.rdata_valid), 32'd0);
        check_vec("t6_rdata_hold", bus.rdata, 32'h55AA33CC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
